// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the multi-cycle MIPS control FSM:
// state encoding, opcode/funct values, reset vector and decode helpers.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_MEM    = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_LWR    = 6'h26;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    function automatic logic is_load(input logic [5:0] op);
        return (op >= OP_LB) && (op <= OP_LWR);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    // Byte lanes for a data access; sub-word lanes move up with the low address bits.
    function automatic logic [3:0] mem_byteenable(input logic [5:0] op, input logic [1:0] ofs);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 4'b0001 << ofs;
            OP_LH, OP_LHU, OP_SH: return 4'b0011 << ofs;
            default:              return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_pc.sv
// Program-counter pair (pc / pc_next) implementing the branch delay slot,
// together with the branch/jump decision and target selection.
module mips_cpu_pc
    import mips_cpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        advance_i,
    input  logic        sig_branch_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs_content_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_next_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_next_q;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] target;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        taken;

    assign opcode        = instr_i[31:26];
    assign funct         = instr_i[5:0];
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr_i[25:0], 2'b00};

    // Decide whether the instruction in IR redirects control flow, and where to.
    always_comb begin
        taken  = 1'b0;
        target = branch_target;
        if ((opcode == OP_J) || (opcode == OP_JAL)) begin
            taken  = 1'b1;
            target = jump_target;
        end else if ((opcode == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR))) begin
            taken  = 1'b1;
            target = rs_content_i;
        end else if ((opcode == OP_REGIMM) || ((opcode >= OP_BEQ) && (opcode <= OP_BGTZ))) begin
            taken  = sig_branch_i;
        end
    end

    // Shift the pair when EXEC retires: the delay slot always runs before the target.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q      <= RESET_VECTOR;
            pc_next_q <= RESET_VECTOR + 32'd4;
        end else if (advance_i) begin
            pc_q      <= pc_next_q;
            pc_next_q <= taken ? target : (pc_next_q + 32'd4);
        end
    end

    assign pc_o      = pc_q;
    assign pc_next_o = pc_next_q;

endmodule

// File: rtl/mips_cpu_control_fsm.sv
// Multi-cycle MIPS control FSM: FETCH / EXEC / MEM / HALTED sequencing,
// instruction register, bus strobes and register-file write strobe.
module mips_cpu_control_fsm
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        sig_branch,
    input  logic        link,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs_content,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic        reg_we,
    output logic        active,
    output logic [1:0]  state
);

    state_t      state_q;
    logic [31:0] ir_q;
    logic        active_q;
    logic [31:0] pc_w;
    logic [31:0] pc_next_w;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        is_ld;
    logic        is_st;
    logic        exec_we;
    logic        advance;

    assign opcode  = ir_q[31:26];
    assign funct   = ir_q[5:0];
    assign is_ld   = is_load(opcode);
    assign is_st   = is_store(opcode);
    assign advance = (state_q == ST_EXEC) && !reset;

    assign exec_we = ((opcode == OP_RTYPE) && (funct != FN_JR))
                   || ((opcode >= OP_ADDIU) && (opcode <= OP_LUI))
                   || (opcode == OP_JAL)
                   || ((opcode == OP_REGIMM) && link);

    mips_cpu_pc u_pc (
        .clk_i        (clk),
        .reset_i      (reset),
        .advance_i    (advance),
        .sig_branch_i (sig_branch),
        .instr_i      (ir_q),
        .rs_content_i (rs_content),
        .pc_o         (pc_w),
        .pc_next_o    (pc_next_w)
    );

    // Sequencer: a transition that would fetch from address 0 halts instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            ir_q     <= 32'd0;
            active_q <= 1'b1;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!waitrequest) begin
                        ir_q    <= readdata;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_ld || is_st) begin
                        state_q <= ST_MEM;
                    end else if (pc_next_w == 32'd0) begin
                        state_q  <= ST_HALTED;
                        active_q <= 1'b0;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (!waitrequest) begin
                        if (pc_w == 32'd0) begin
                            state_q  <= ST_HALTED;
                            active_q <= 1'b0;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= ST_HALTED;
                end
            endcase
        end
    end

    // Bus and write-strobe decode from the current state; reset kills all strobes at once.
    always_comb begin
        address    = pc_w;
        read       = 1'b0;
        write      = 1'b0;
        byteenable = 4'b1111;
        reg_we     = 1'b0;
        case (state_q)
            ST_FETCH: read = 1'b1;
            ST_EXEC:  reg_we = exec_we;
            ST_MEM: begin
                address    = {alu_result[31:2], 2'b00};
                byteenable = mem_byteenable(opcode, alu_result[1:0]);
                read       = is_ld;
                write      = is_st;
                reg_we     = is_ld && !waitrequest;
            end
            default: ;
        endcase
        if (reset) begin
            read   = 1'b0;
            write  = 1'b0;
            reg_we = 1'b0;
        end
    end

    assign instr  = ir_q;
    assign pc     = pc_w;
    assign active = active_q;
    assign state  = state_q;

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
// Scenario bench for mips_cpu_control_fsm: each task drives a per-cycle
// stimulus table, queues the expected bus view and compares at the falling edge.
module tb_mips_cpu_control_fsm;

    localparam logic [31:0] RV    = 32'hBFC0_0000;
    localparam logic [31:0] ADDIU = 32'h2402_0005;
    localparam logic [31:0] BEQ4  = 32'h1000_0004;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] LW    = 32'h8C02_0000;
    localparam logic [31:0] SB    = 32'hA002_0000;
    localparam logic [31:0] SH    = 32'hA402_0000;
    localparam logic [31:0] JR    = 32'h03E0_0008;

    typedef struct packed {
        logic [1:0]  st;
        logic        rd;
        logic        wr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
    } obs_t;

    typedef struct packed {
        logic        rst;
        logic [31:0] rdata;
        logic        wt;
        logic        sb;
        logic [31:0] alu;
        logic [31:0] rs;
        obs_t        exp;
    } cyc_t;

    logic        clk;
    logic        reset;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        sig_branch;
    logic        link;
    logic [31:0] alu_result;
    logic [31:0] rs_content;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic        reg_we;
    logic        active;
    logic [1:0]  state;

    int   n_checks = 0;
    int   n_errors = 0;
    obs_t exp_q[$];

    mips_cpu_control_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .sig_branch  (sig_branch),
        .link        (link),
        .alu_result  (alu_result),
        .rs_content  (rs_content),
        .instr       (instr),
        .pc          (pc),
        .address     (address),
        .read        (read),
        .write       (write),
        .byteenable  (byteenable),
        .reg_we      (reg_we),
        .active      (active),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic cyc_t mk(input logic rst, input logic [31:0] rdata, input logic wt,
                                input logic sb, input logic [31:0] alu, input logic [31:0] rs,
                                input logic [1:0] st, input logic rd, input logic wr, input logic we,
                                input logic [3:0] be, input logic [31:0] addr);
        cyc_t c;
        c.rst = rst; c.rdata = rdata; c.wt = wt; c.sb = sb; c.alu = alu; c.rs = rs;
        c.exp.st = st; c.exp.rd = rd; c.exp.wr = wr; c.exp.we = we; c.exp.be = be; c.exp.addr = addr;
        return c;
    endfunction

    // Address and lanes only matter while a strobe is up.
    function automatic obs_t mask(input obs_t o);
        if (!o.rd && !o.wr) begin
            o.be   = 4'd0;
            o.addr = 32'd0;
        end
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.st = state; o.rd = read; o.wr = write; o.we = reg_we; o.be = byteenable; o.addr = address;
        return o;
    endfunction

    // Apply one cycle of stimulus, queue its expectation, move to the sampling edge.
    task automatic drive(input cyc_t c);
        reset       = c.rst;
        readdata    = c.rdata;
        waitrequest = c.wt;
        sig_branch  = c.sb;
        alu_result  = c.alu;
        rs_content  = c.rs;
        exp_q.push_back(c.exp);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; waitrequest = 1'b0; readdata = NOP;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cyc_t tab[$];
        obs_t e, g;
        do_reset();
        tab.push_back(mk(1, ADDIU, 0, 0, 0, 0, 2'd0, 0, 0, 0, 4'hF, RV));
        tab.push_back(mk(0, ADDIU, 1, 0, 0, 0, 2'd0, 1, 0, 0, 4'hF, RV));
        tab.push_back(mk(0, ADDIU, 1, 0, 0, 0, 2'd0, 1, 0, 0, 4'hF, RV));
        foreach (tab[i]) begin
            drive(tab[i]);
            e = mask(exp_q.pop_front()); g = mask(observe());
            n_checks++;
            if (g !== e) begin n_errors++; $display("FAIL reset cycle %0d: got %h required %h", i, g, e); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if (pc !== RV) begin n_errors++; $display("FAIL reset_pc: got %h required %h", pc, RV); end
        n_checks++;
        if (instr !== 32'd0) begin n_errors++; $display("FAIL reset_ir: got %h required 0", instr); end
        n_checks++;
        if (active !== 1'b1) begin n_errors++; $display("FAIL reset_active: got %b required 1", active); end
    endtask

    task automatic test_addiu();
        cyc_t tab[$];
        obs_t e, g;
        do_reset();
        tab.push_back(mk(0, ADDIU, 0, 0, 0, 0, 2'd0, 1, 0, 0, 4'hF, RV));
        tab.push_back(mk(0, ADDIU, 0, 0, 0, 0, 2'd1, 0, 0, 1, 4'hF, RV));
        tab.push_back(mk(0, ADDIU, 0, 0, 0, 0, 2'd0, 1, 0, 0, 4'hF, RV + 32'd4));
        foreach (tab[i]) begin
            drive(tab[i]);
            e = mask(exp_q.pop_front()); g = mask(observe());
            n_checks++;
            if (g !== e) begin n_errors++; $display("FAIL addiu cycle %0d: got %h required %h", i, g, e); end
            @(posedge clk); #1;
        end
        n_checks++;
        if (instr !== ADDIU) begin n_errors++; $display("FAIL addiu_ir: got %h required %h", instr, ADDIU); end
    endtask

    task automatic test_branch();
        cyc_t tab[$];
        obs_t e, g;
        do_reset();
        tab.push_back(mk(0, BEQ4, 0, 1, 0, 0, 2'd0, 1, 0, 0, 4'hF, RV));
        tab.push_back(mk(0, NOP,  0, 1, 0, 0, 2'd1, 0, 0, 0, 4'hF, RV));
        tab.push_back(mk(0, NOP,  0, 0, 0, 0, 2'd0, 1, 0, 0, 4'hF, RV + 32'h04));
        tab.push_back(mk(0, BEQ4, 0, 0, 0, 0, 2'd1, 0, 0, 1, 4'hF, RV));
        tab.push_back(mk(0, BEQ4, 0, 0, 0, 0, 2'd0, 1, 0, 0, 4'hF, RV + 32'h14));
        tab.push_back(mk(0, NOP,  0, 0, 0, 0, 2'd1, 0, 0, 0, 4'hF, RV));
        tab.push_back(mk(0, NOP,  0, 0, 0, 0, 2'd0, 1, 0, 0, 4'hF, RV + 32'h18));
        foreach (tab[i]) begin
            drive(tab[i]);
            e = mask(exp_q.pop_front()); g = mask(observe());
            n_checks++;
            if (g !== e) begin n_errors++; $display("FAIL branch cycle %0d: got %h required %h", i, g, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_stall();
        cyc_t tab[$];
        obs_t e, g;
        do_reset();
        tab.push_back(mk(0, LW,  0, 0, 32'h1006, 0, 2'd0, 1, 0, 0, 4'hF, RV));
        tab.push_back(mk(0, LW,  0, 0, 32'h1006, 0, 2'd1, 0, 0, 0, 4'hF, RV));
        tab.push_back(mk(0, LW,  1, 0, 32'h1006, 0, 2'd2, 1, 0, 0, 4'hF, 32'h1004));
        tab.push_back(mk(0, LW,  1, 0, 32'h1006, 0, 2'd2, 1, 0, 0, 4'hF, 32'h1004));
        tab.push_back(mk(0, LW,  1, 0, 32'h1006, 0, 2'd2, 1, 0, 0, 4'hF, 32'h1004));
        tab.push_back(mk(0, NOP, 0, 0, 32'h1006, 0, 2'd2, 1, 0, 1, 4'hF, 32'h1004));
        tab.push_back(mk(0, NOP, 0, 0, 0,        0, 2'd0, 1, 0, 0, 4'hF, RV + 32'd4));
        tab.push_back(mk(0, NOP, 0, 0, 0,        0, 2'd1, 0, 0, 1, 4'hF, RV));
        foreach (tab[i]) begin
            drive(tab[i]);
            e = mask(exp_q.pop_front()); g = mask(observe());
            n_checks++;
            if (g !== e) begin n_errors++; $display("FAIL load cycle %0d: got %h required %h", i, g, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_lanes();
        cyc_t tab[$];
        obs_t e, g;
        do_reset();
        tab.push_back(mk(0, SB,  0, 0, 32'h13,   0, 2'd0, 1, 0, 0, 4'hF,    RV));
        tab.push_back(mk(0, SB,  0, 0, 32'h13,   0, 2'd1, 0, 0, 0, 4'hF,    RV));
        tab.push_back(mk(0, SH,  0, 0, 32'h13,   0, 2'd2, 0, 1, 0, 4'b1000, 32'h10));
        tab.push_back(mk(0, SH,  0, 0, 32'h2002, 0, 2'd0, 1, 0, 0, 4'hF,    RV + 32'd4));
        tab.push_back(mk(0, SH,  0, 0, 32'h2002, 0, 2'd1, 0, 0, 0, 4'hF,    RV));
        tab.push_back(mk(0, NOP, 0, 0, 32'h2002, 0, 2'd2, 0, 1, 0, 4'b1100, 32'h2000));
        tab.push_back(mk(0, NOP, 0, 0, 0,        0, 2'd0, 1, 0, 0, 4'hF,    RV + 32'd8));
        foreach (tab[i]) begin
            drive(tab[i]);
            e = mask(exp_q.pop_front()); g = mask(observe());
            n_checks++;
            if (g !== e) begin n_errors++; $display("FAIL store cycle %0d: got %h required %h", i, g, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jr_halt();
        cyc_t tab[$];
        obs_t e, g;
        do_reset();
        tab.push_back(mk(0, JR,  0, 0, 0, 0, 2'd0, 1, 0, 0, 4'hF, RV));
        tab.push_back(mk(0, NOP, 0, 0, 0, 0, 2'd1, 0, 0, 0, 4'hF, RV));
        tab.push_back(mk(0, NOP, 0, 0, 0, 0, 2'd0, 1, 0, 0, 4'hF, RV + 32'd4));
        tab.push_back(mk(0, NOP, 0, 0, 0, 0, 2'd1, 0, 0, 1, 4'hF, RV));
        tab.push_back(mk(0, NOP, 0, 0, 0, 0, 2'd3, 0, 0, 0, 4'hF, RV));
        tab.push_back(mk(0, NOP, 0, 0, 0, 0, 2'd3, 0, 0, 0, 4'hF, RV));
        foreach (tab[i]) begin
            drive(tab[i]);
            e = mask(exp_q.pop_front()); g = mask(observe());
            n_checks++;
            if (g !== e) begin n_errors++; $display("FAIL jr_halt cycle %0d: got %h required %h", i, g, e); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if (active !== 1'b0) begin n_errors++; $display("FAIL halt_active: got %b required 0", active); end
        @(posedge clk); #1;
        tab.delete();
        tab.push_back(mk(1, NOP,   0, 0, 0, 0, 2'd3, 0, 0, 0, 4'hF, RV));
        tab.push_back(mk(0, ADDIU, 0, 0, 0, 0, 2'd0, 1, 0, 0, 4'hF, RV));
        foreach (tab[i]) begin
            drive(tab[i]);
            e = mask(exp_q.pop_front()); g = mask(observe());
            n_checks++;
            if (g !== e) begin n_errors++; $display("FAIL halt_restart cycle %0d: got %h required %h", i, g, e); end
            @(posedge clk); #1;
        end
        n_checks++;
        if (active !== 1'b1) begin n_errors++; $display("FAIL restart_active: got %b required 1", active); end
    endtask

    task automatic test_reset_mid_stall();
        cyc_t tab[$];
        obs_t e, g;
        do_reset();
        tab.push_back(mk(0, LW,  0, 0, 32'h1006, 0, 2'd0, 1, 0, 0, 4'hF, RV));
        tab.push_back(mk(0, LW,  0, 0, 32'h1006, 0, 2'd1, 0, 0, 0, 4'hF, RV));
        tab.push_back(mk(0, LW,  1, 0, 32'h1006, 0, 2'd2, 1, 0, 0, 4'hF, 32'h1004));
        tab.push_back(mk(1, LW,  1, 0, 32'h1006, 0, 2'd2, 0, 0, 0, 4'hF, 32'h1004));
        tab.push_back(mk(0, NOP, 1, 0, 0,        0, 2'd0, 1, 0, 0, 4'hF, RV));
        tab.push_back(mk(0, NOP, 0, 0, 0,        0, 2'd0, 1, 0, 0, 4'hF, RV));
        foreach (tab[i]) begin
            drive(tab[i]);
            e = mask(exp_q.pop_front()); g = mask(observe());
            n_checks++;
            if (g !== e) begin n_errors++; $display("FAIL mid_stall_reset cycle %0d: got %h required %h", i, g, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset       = 1'b1;
        waitrequest = 1'b0;
        readdata    = NOP;
        sig_branch  = 1'b0;
        link        = 1'b0;
        alu_result  = 32'd0;
        rs_content  = 32'd0;
        @(posedge clk); #1;
        test_reset();
        test_addiu();
        test_branch();
        test_load_stall();
        test_store_lanes();
        test_jr_halt();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_cpu_control_fsm.md
MIPS_CPU_CONTROL_FSM -- requirements
Module: mips_cpu_control_fsm

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 waitrequest  in  1  memory stall; current bus transfer not complete while high.
REQ-004 readdata  in  32  memory read data; instruction word in FETCH.
REQ-005 sig_branch  in  1  branch-taken flag from ALU, valid in EXEC.
REQ-006 link  in  1  ALU link flag (BLTZAL/BGEZAL taken), valid in EXEC.
REQ-007 alu_result  in  32  ALU output; effective address for loads/stores.
REQ-008 rs_content  in  32  register rs value; JR/JALR target.
REQ-009 instr  out  32  latched instruction register (IR).
REQ-010 pc  out  32  address of the instruction in IR.
REQ-011 address  out  32  word-aligned bus address.
REQ-012 read, write  out  1 each  bus strobes.
REQ-013 byteenable  out  4  bus byte lanes.
REQ-014 reg_we  out  1  register-file write strobe, one cycle.
REQ-015 active  out  1  high until halt.
REQ-016 state  out  2  FETCH=0, EXEC=1, MEM=2, HALTED=3.

Function
REQ-017 FETCH: address=pc, read=1, byteenable=1111; on waitrequest=0, IR<=readdata and next state is EXEC; otherwise stay in FETCH.
REQ-018 EXEC lasts exactly one cycle; loads (opcode 0x20-0x26) and stores (0x28-0x2B) go to MEM; all other opcodes go to FETCH.
REQ-019 reg_we=1 in EXEC for: R-type except JR (funct 0x08); opcodes 0x09-0x0F; JAL (0x03); REGIMM with link=1.
REQ-020 MEM: address={alu_result[31:2],2'b00}; read=1 for loads, write=1 for stores; hold all outputs while waitrequest=1; on waitrequest=0, reg_we=1 for loads, then go to FETCH.
REQ-021 byteenable in MEM: word ops 1111; halfword ops 0011 shifted left by alu_result[1:0]; byte ops 0001 shifted left by alu_result[1:0].
REQ-022 Delay slot: internal pc_next register; on leaving EXEC, pc<=pc_next; pc_next<=target if taken, else pc_next+4.
REQ-023 Taken if: sig_branch=1 for opcodes 0x01, 0x04-0x07; always for J/JAL/JR/JALR.
REQ-024 Targets: branch = pc+4+(sign-extended imm<<2); J/JAL = {pc+4 [31:28], instr[25:0], 2'b00}; JR/JALR = rs_content.
REQ-025 A branch in a delay slot follows REQ-022 unchanged; no exception is raised.
REQ-026 Halt: on any transition into FETCH with new pc==0x00000000, go to HALTED instead; no fetch from address 0 is issued.
REQ-027 HALTED is absorbing until reset: active=0, read=write=reg_we=0.
REQ-028 read, write, reg_we and IR load are never high in the same cycle as a state other than the one that owns them.
REQ-029 All 32-bit PC arithmetic wraps modulo 2^32.

Reset
REQ-030 With reset=1 at a clock edge: state<=FETCH, pc<=0xBFC00000, pc_next<=0xBFC00004, IR<=0, active<=1.
REQ-031 While reset=1, read, write, reg_we=0 combinationally.
REQ-032 Reset during a FETCH/MEM stall aborts the transfer; no IR load or reg_we occurs.
REQ-033 Reset from HALTED restarts normally.

Structure
REQ-034 Package mips_cpu_pkg holds: state enum, opcode/funct constants, reset vector 0xBFC00000.
REQ-035 pc/pc_next pair and target mux live in a sub-module mips_cpu_pc; FSM and bus logic stay in the top module.

Verification
REQ-036 Release reset, waitrequest=0, readdata=ADDIU 0x24020005 -> FETCH(addr 0xBFC00000) then EXEC with reg_we=1; next fetch at 0xBFC00004.
REQ-037 BEQ offset 4 with sig_branch=1 at 0xBFC00000 -> delay slot fetched at 0xBFC00004, then fetch at 0xBFC00014.
REQ-038 LW with alu_result=0x00001006 and waitrequest high 3 cycles -> address 0x00001004, read held 4 cycles, reg_we pulses once, and the next fetch starts after it.
REQ-039 SB with alu_result=0x00000013 -> write=1, byteenable=1000, reg_we=0.
REQ-040 JR with rs_content=0 plus NOP delay slot -> delay slot executes, then state=HALTED, active=0, no read at address 0.
REQ-041 Reset asserted mid-MEM stall -> next cycle state=FETCH, pc=0xBFC00000, no reg_we pulse.
